// File: rtl/map_write_arbiter.sv
// map_write_arbiter
//   Sole owner of write port b of the shared tile-map RAM. It either runs a
//   full-map initialisation sweep from the level ROM, or round-robin
//   arbitrates single-tile writes from NREQ gameplay clients. Its ram_*
//   outputs fan out to every map RAM copy, so the copies stay coherent.
//
// Ports
//   Clk, Reset       clock, async active-high reset
//   init_start       one-cycle pulse, starts a sweep (ignored while busy)
//   init_data        ROM tile code for init_addr (same cycle)
//   init_addr        sweep address to the level ROM (= sweep counter)
//   req/req_addr/    per-client level request, 10-bit tile address and
//   req_data         4-bit tile code, client i in slice i
//   gnt              one-cycle grant pulse, one-hot or zero
//   busy             high while the sweep runs
//   ram_en/addr/data write port b of the map RAM
//   drop_count       saturating count of granted out-of-range writes
module map_write_arbiter #(
  parameter int NREQ  = 3,
  parameter int MAP_W = 20,
  parameter int MAP_H = 15
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               init_start,
  input  logic [3:0]         init_data,
  output logic [9:0]         init_addr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*10-1:0] req_addr,
  input  logic [NREQ*4-1:0]  req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               ram_en,
  output logic [9:0]         ram_addr,
  output logic [3:0]         ram_data,
  output logic [7:0]         drop_count
);

  localparam int         MAP_SIZE = MAP_W * MAP_H;
  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [9:0] LAST     = 10'(MAP_SIZE - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                 state, state_n;
  logic [9:0]             cnt, cnt_n;
  logic [PW-1:0]          ptr, ptr_n;
  logic [NREQ-1:0]        gnt_n;
  logic                   busy_n, en_n;
  logic [9:0]             addr_n;
  logic [3:0]             data_n;
  logic [7:0]             drop_n;

  logic [NREQ-1:0][9:0]   addr_v;
  logic [NREQ-1:0][3:0]   data_v;
  logic [NREQ-1:0]        elig;
  logic                   win_found;
  logic [PW-1:0]          win;
  logic [PW:0]            idx;

  assign addr_v    = req_addr;
  assign data_v    = req_data;
  assign init_addr = cnt;

  // Last cycle's winner sits out one cycle so it can drop or change its
  // request after seeing gnt.
  assign elig = req & ~gnt;

  // Rotating priority search starting at ptr. idx is one bit wider than ptr
  // so ptr+k never overflows before the modulo-NREQ fold.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (PW+1)'(ptr) + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win       = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gnt_n   = '0;
    busy_n  = busy;
    en_n    = 1'b0;
    addr_n  = ram_addr;
    data_n  = ram_data;
    drop_n  = drop_count;
    case (state)
      SWEEP: begin
        en_n   = 1'b1;
        addr_n = cnt;
        data_n = init_data;
        if (cnt == LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      default: begin
        if (init_start) begin
          // A sweep start beats any request presented at the same edge.
          state_n = SWEEP;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end else if (win_found) begin
          gnt_n = NREQ'(1) << win;
          ptr_n = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          if (addr_v[win] < 10'(MAP_SIZE)) begin
            en_n   = 1'b1;
            addr_n = addr_v[win];
            data_n = data_v[win];
          end else if (drop_count != 8'hFF) begin
            drop_n = drop_count + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ptr        <= ptr_n;
      gnt        <= gnt_n;
      busy       <= busy_n;
      ram_en     <= en_n;
      ram_addr   <= addr_n;
      ram_data   <= data_n;
      drop_count <= drop_n;
    end
  end

endmodule

// File: tb/tb_map_write_arbiter.sv
// Bench for map_write_arbiter: directed scenarios plus a randomized phase.
// A behavioural model predicts every cycle's outputs into a queue; an
// independent monitor pops and compares one record per clock.
module tb_map_write_arbiter;
  localparam int NREQ = 3;
  localparam int MAP_SIZE = 300;

  logic               Clk = 1'b0;
  logic               Reset, init_start;
  logic [3:0]         init_data;
  logic [9:0]         init_addr;
  logic [NREQ-1:0]    req, gnt;
  logic [NREQ*10-1:0] req_addr;
  logic [NREQ*4-1:0]  req_data;
  logic               busy, ram_en;
  logic [9:0]         ram_addr;
  logic [3:0]         ram_data;
  logic [7:0]         drop_count;

  map_write_arbiter #(.NREQ(NREQ), .MAP_W(20), .MAP_H(15)) dut (
    .Clk(Clk), .Reset(Reset), .init_start(init_start), .init_data(init_data),
    .init_addr(init_addr), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .busy(busy), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_data(ram_data), .drop_count(drop_count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom(input logic [9:0] a);
    return a[3:0] ^ a[7:4];
  endfunction

  assign init_data = rom(init_addr);

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] gnt;
    logic            en;
    logic [9:0]      addr;
    logic [3:0]      data;
    logic            busy;
    logic [7:0]      drop;
    logic [9:0]      iaddr;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;

  // reference model state
  bit            m_sweep;
  int            m_cnt, m_ptr, m_last, m_addr, m_data, m_drop;
  bit            m_en;
  bit [NREQ-1:0] m_gnt;

  // clients: mode 0 idle, 1 hold a fixed request forever, 2 random
  bit c_req[NREQ];
  int c_addr[NREQ], c_data[NREQ], c_mode[NREQ];
  bit s_init, s_rst;
  int busy_cnt;

  task automatic model_reset();
    m_sweep = 0; m_cnt = 0; m_ptr = 0; m_last = -1;
    m_addr = 0; m_data = 0; m_drop = 0; m_en = 0; m_gnt = '0;
  endtask

  task automatic new_req(input int i);
    c_req[i]  = 1;
    c_addr[i] = $urandom_range(0, 330);
    c_data[i] = $urandom_range(0, 15);
  endtask

  task automatic model_edge();
    int w;
    if (s_rst) begin
      model_reset();
    end else if (m_sweep) begin
      m_en = 1; m_addr = m_cnt; m_data = rom(10'(m_cnt));
      m_gnt = '0; m_last = -1;
      if (m_cnt == MAP_SIZE - 1) begin m_sweep = 0; m_cnt = 0; end
      else m_cnt++;
    end else if (s_init) begin
      m_sweep = 1; m_cnt = 0; m_en = 0; m_gnt = '0; m_last = -1;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (w < 0 && c_req[c] && c != m_last) w = c;
      end
      m_gnt = '0;
      if (w < 0) begin
        m_en = 0; m_last = -1;
      end else begin
        m_gnt[w] = 1'b1;
        m_ptr = (w + 1) % NREQ;
        m_last = w;
        if (c_addr[w] < MAP_SIZE) begin
          m_en = 1; m_addr = c_addr[w]; m_data = c_data[w];
        end else begin
          m_en = 0;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  endtask

  // One clock of stimulus: clients react to the grant visible this cycle,
  // inputs are driven, and the model predicts the next edge's outputs.
  task automatic step();
    exp_t e;
    @(negedge Clk);
    for (int i = 0; i < NREQ; i++) begin
      case (c_mode[i])
        0: c_req[i] = 0;
        1: c_req[i] = 1;
        default: begin
          if (c_req[i] && m_last == i) begin
            if ($urandom_range(0, 1) == 1) c_req[i] = 0; else new_req(i);
          end else if (!c_req[i] && $urandom_range(0, 2) == 0) new_req(i);
        end
      endcase
    end
    Reset = s_rst;
    init_start = s_init;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = c_req[i];
      req_addr[10*i +: 10] = 10'(c_addr[i]);
      req_data[4*i +: 4] = 4'(c_data[i]);
    end
    model_edge();
    e.cyc = cyc + 1; e.gnt = m_gnt; e.en = m_en; e.addr = 10'(m_addr);
    e.data = 4'(m_data); e.busy = m_sweep; e.drop = 8'(m_drop); e.iaddr = 10'(m_cnt);
    sb.push_back(e);
    s_init = 0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_modes(input int m);
    for (int i = 0; i < NREQ; i++) c_mode[i] = m;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (gnt !== '0 || ram_en !== 1'b0 || ram_addr !== '0 || ram_data !== '0 ||
        busy !== 1'b0 || drop_count !== '0 || init_addr !== '0) begin
      errors++;
      $display("FAIL %s: got gnt=%b en=%b addr=%0d data=%0d busy=%b drop=%0d iaddr=%0d, required all zero",
               name, gnt, ram_en, ram_addr, ram_data, busy, drop_count, init_addr);
    end
  endtask

  task automatic sweep_until_done(input string name);
    int guard;
    guard = 0;
    while (m_sweep && guard < 400) begin step(); guard++; end
    checks++;
    if (m_sweep) begin
      errors++;
      $display("FAIL %s: sweep bound expired after %0d cycles, required end within 400", name, guard);
    end
  endtask

  // monitor: one predicted record per clock
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || gnt !== e.gnt || ram_en !== e.en || ram_addr !== e.addr ||
            ram_data !== e.data || busy !== e.busy || drop_count !== e.drop ||
            init_addr !== e.iaddr) begin
          errors++;
          $display("FAIL outputs cyc=%0d: got gnt=%b en=%b addr=%0d data=%0d busy=%b drop=%0d iaddr=%0d, required tag=%0d gnt=%b en=%b addr=%0d data=%0d busy=%b drop=%0d iaddr=%0d",
                   cyc, gnt, ram_en, ram_addr, ram_data, busy, drop_count, init_addr,
                   e.cyc, e.gnt, e.en, e.addr, e.data, e.busy, e.drop, e.iaddr);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; init_start = 1'b0; req = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      c_req[i] = 0; c_addr[i] = 0; c_data[i] = 0; c_mode[i] = 0;
    end
    s_init = 0; s_rst = 1;
    model_reset();
    run(3);
    check_zero("reset_state");
    s_rst = 0;
    run(2);

    // round robin, all three holding
    c_addr[0] = 10; c_addr[1] = 20; c_addr[2] = 30;
    c_data[0] = 1;  c_data[1] = 2;  c_data[2] = 3;
    set_modes(1);
    run(8);
    set_modes(0);
    run(3);

    // single continuous client
    c_mode[1] = 1; c_addr[1] = 55; c_data[1] = 7;
    run(8);
    c_mode[1] = 0;
    run(3);

    // out-of-range address, drive drop_count into saturation
    c_mode[2] = 1; c_addr[2] = 300; c_data[2] = 5;
    run(620);
    c_mode[2] = 0;
    run(2);
    checks++;
    if (drop_count !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d, required 255", drop_count);
    end

    // reset in the middle of a sweep
    s_init = 1;
    step();
    while (m_sweep && m_cnt != 100) step();
    s_rst = 1;
    step();
    #1;
    check_zero("reset_mid_sweep");
    run(2);
    s_rst = 0;
    run(20);

    // full sweep, with a stray init_start in the middle
    busy_cnt = 0;
    s_init = 1;
    step();
    for (int i = 0; i < 50; i++) begin step(); if (busy) busy_cnt++; end
    s_init = 1;
    while (m_sweep && busy_cnt < 400) begin step(); if (busy) busy_cnt++; end
    for (int i = 0; i < 4; i++) begin step(); if (busy) busy_cnt++; end
    checks++;
    if (busy_cnt != MAP_SIZE) begin
      errors++;
      $display("FAIL busy_width: got %0d cycles, required %0d", busy_cnt, MAP_SIZE);
    end

    // collision of init_start with a request
    c_mode[0] = 1; c_addr[0] = 77; c_data[0] = 9;
    s_init = 1;
    step();
    sweep_until_done("collision_sweep");
    run(4);
    c_mode[0] = 0;
    run(3);

    // randomized traffic, sweeps and resets
    set_modes(2);
    for (int n = 0; n < 6000; n++) begin
      s_init = ($urandom_range(0, 199) == 0);
      s_rst  = ($urandom_range(0, 1999) == 0);
      step();
    end
    s_rst = 0;
    set_modes(0);
    run(2);
    sweep_until_done("final_sweep");
    run(2);

    @(posedge Clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending records, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
